// File: rtl/fir_pkg.sv
// Shared constants, coefficient ROM and state encoding for the 32-tap FIR low-pass stage.
package fir_pkg;

    localparam int TAPS       = 32;
    localparam int DW         = 16;
    localparam int CW         = 20;
    localparam int FRAME      = 1024;
    localparam int PROD_W     = DW + CW;
    localparam int ACC_W      = PROD_W + $clog2(TAPS);
    localparam int CNT_W      = $clog2(FRAME);
    localparam int FRAC_SHIFT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fir_state_e;

    // Symmetric windowed low-pass in Q4.16; DC gain is 70272/65536.
    localparam logic signed [CW-1:0] FIR_COEF [TAPS] = '{
        -20'sd320,  -20'sd192,    20'sd0,   20'sd256,
          20'sd640,  20'sd1088,  20'sd1600, 20'sd2112,
          20'sd2624, 20'sd3072,  20'sd3456, 20'sd3776,
          20'sd4032, 20'sd4224,  20'sd4352, 20'sd4416,
          20'sd4416, 20'sd4352,  20'sd4224, 20'sd4032,
          20'sd3776, 20'sd3456,  20'sd3072, 20'sd2624,
          20'sd2112, 20'sd1600,  20'sd1088, 20'sd640,
          20'sd256,    20'sd0,   -20'sd192, -20'sd320
    };

endpackage

// File: rtl/fir_if.sv
// Streaming bundle between the sample source, the FIR stage (slave) and the FFT input.
interface fir_if;
    import fir_pkg::*;

    logic                 data_valid;
    logic signed [DW-1:0] data;
    logic                 fir_valid;
    logic signed [DW-1:0] fir_d;
    logic                 fir_last;
    logic                 busy;

    modport master (
        output data_valid, data,
        input  fir_valid, fir_d, fir_last, busy
    );

    modport slave (
        input  data_valid, data,
        output fir_valid, fir_d, fir_last, busy
    );

endinterface

// File: rtl/fir_round_sat.sv
// Q12.24 accumulator to Q8.8 sample: round half up, then saturate (FIR_SAT_EN) or wrap.
module fir_round_sat
    import fir_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [DW-1:0]    o_data
);

    localparam int SH_W = ACC_W - FRAC_SHIFT;
    localparam logic signed [ACC_W-1:0] HALF_LSB =
        {{(ACC_W - FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT - 1){1'b0}}};

    logic signed [ACC_W-1:0] w_biased;
    logic signed [SH_W-1:0]  w_shift;
    logic                    w_unused;

    assign w_biased = i_acc + HALF_LSB;
    assign w_shift  = w_biased[ACC_W-1:FRAC_SHIFT];

`ifdef FIR_SAT_EN
    logic [SH_W-DW:0] w_hi;

    assign w_hi     = w_shift[SH_W-1:DW-1];
    assign w_unused = ^w_biased[FRAC_SHIFT-1:0];

    // In range when every bit above the output sign agrees with it; otherwise clamp by sign.
    always_comb begin
        o_data = w_shift[DW-1:0];
        if ((&w_hi) || (~|w_hi)) begin
            o_data = w_shift[DW-1:0];
        end else if (w_shift[SH_W-1]) begin
            o_data = {1'b1, {(DW - 1){1'b0}}};
        end else begin
            o_data = {1'b0, {(DW - 1){1'b1}}};
        end
    end
`else
    assign w_unused = ^{w_biased[FRAC_SHIFT-1:0], w_shift[SH_W-1:DW]};

    // Two's-complement wrap: keep the low DW bits of the rounded value.
    always_comb begin
        o_data = w_shift[DW-1:0];
    end
`endif

endmodule

// File: rtl/fir_filter.sv
// Streaming 32-tap direct-form FIR feeding the FFT; latency 3, halts after one frame.
// Build option: define FIR_SAT_EN to clamp outputs instead of wrapping.
module fir_filter
    import fir_pkg::*;
(
    input  logic clk,
    input  logic rst,
    fir_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

    fir_state_e                r_state;
    logic signed [DW-1:0]      r_x    [TAPS];
    logic signed [PROD_W-1:0]  r_prod [TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic [2:0]                r_vld;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_fir_valid;
    logic                      r_fir_last;
    logic                      r_busy;
    logic signed [DW-1:0]      r_fir_d;

    logic                      w_accept;
    logic signed [ACC_W-1:0]   w_acc;
    logic signed [DW-1:0]      w_rounded;

    assign w_accept = bus.data_valid && (r_state != DONE);

    // Delay line: shifts only on accepted samples, so gaps leave the history untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= {DW{1'b0}};
            end
        end else if (w_accept) begin
            r_x[0] <= bus.data;
            for (int i = 1; i < TAPS; i++) begin
                r_x[i] <= r_x[i-1];
            end
        end
    end

    // Adder tree over the registered products; wide enough that it never overflows.
    always_comb begin
        w_acc = {ACC_W{1'b0}};
        for (int i = 0; i < TAPS; i++) begin
            w_acc = w_acc + ACC_W'(r_prod[i]);
        end
    end

    // Datapath stages: products then sum; validity travels separately in r_vld.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_prod[i] <= {PROD_W{1'b0}};
            end
            r_acc <= {ACC_W{1'b0}};
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                r_prod[i] <= PROD_W'(r_x[i]) * PROD_W'(FIR_COEF[i]);
            end
            r_acc <= w_acc;
        end
    end

    fir_round_sat u_round_sat (
        .i_acc  (r_acc),
        .o_data (w_rounded)
    );

    // Control FSM with registered outputs; in-flight samples are dropped once DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_vld       <= 3'b000;
            r_cnt       <= {CNT_W{1'b0}};
            r_fir_valid <= 1'b0;
            r_fir_last  <= 1'b0;
            r_fir_d     <= {DW{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            r_vld       <= {r_vld[1:0], w_accept};
            r_fir_valid <= 1'b0;
            r_fir_last  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_vld[2]) begin
                        r_fir_valid <= 1'b1;
                        r_fir_d     <= w_rounded;
                        r_cnt       <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_LAST) begin
                            r_fir_last <= 1'b1;
                            r_state    <= DONE;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fir_valid = r_fir_valid;
    assign bus.fir_d     = r_fir_d;
    assign bus.fir_last  = r_fir_last;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_fir_filter.sv
// Directed self-checking bench for fir_filter: impulse, DC, gaps, overflow, frame end, reset.
module tb_fir_filter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fir_if bus ();

    fir_filter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int coef [32] = '{
        -320, -192, 0, 256, 640, 1088, 1600, 2112, 2624, 3072, 3456, 3776, 4032, 4224, 4352, 4416,
        4416, 4352, 4224, 4032, 3776, 3456, 3072, 2624, 2112, 1600, 1088, 640, 256, 0, -192, -320
    };

    // round-half-up of coef/256 worked out by hand
    int imp_exp [32] = '{
        -1, -1, 0, 1, 3, 4, 6, 8, 10, 12, 14, 15, 16, 17, 17, 17,
        17, 17, 17, 16, 15, 14, 12, 10, 8, 6, 4, 3, 1, 0, -1, -1
    };

    int          smp    [$];
    int          acc_q  [$];
    int          ocyc_q [$];
    logic [15:0] out_q  [$];
    logic        last_q [$];
    logic        busy_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_out(input int idx);
        longint acc = 0;
        longint r;
        for (int i = 0; i < 32; i++) begin
            if (idx - i >= 0) acc += longint'(smp[idx-i]) * longint'(coef[i]);
        end
        r = (acc + 64'sd32768) >>> 16;
`ifdef FIR_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic clear_log();
        smp.delete(); acc_q.delete(); ocyc_q.delete();
        out_q.delete(); last_q.delete(); busy_q.delete();
    endtask

    task automatic drive_cycle(input logic v, input logic [15:0] d);
        @(negedge clk);
        bus.data_valid = v;
        bus.data       = d;
        @(posedge clk);
        #1;
        cyc++;
        if (v) begin
            acc_q.push_back(cyc);
            smp.push_back(int'($signed(d)));
        end
        if (bus.fir_valid === 1'b1) begin
            out_q.push_back(bus.fir_d);
            last_q.push_back(bus.fir_last);
            busy_q.push_back(bus.busy);
            ocyc_q.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.data_valid = 1'b0;
        bus.data = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_log();
    endtask

    task automatic run_impulse(input string tag);
        drive_cycle(1'b1, 16'h0100);
        for (int i = 0; i < 39; i++) drive_cycle(1'b1, 16'h0000);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'h0000);
        check_eq({tag, "_count"}, 32'(out_q.size()), 32'd40);
        if (out_q.size() == 40) begin
            check_eq({tag, "_latency"}, 32'(ocyc_q[0]), 32'(acc_q[0] + 3));
            for (int i = 0; i < 32; i++)
                check_eq({tag, "_tap"}, {16'h0, out_q[i]}, {16'h0, imp_exp[i][15:0]});
            for (int i = 32; i < 40; i++)
                check_eq({tag, "_tail"}, {16'h0, out_q[i]}, 32'h0);
        end
        check_eq({tag, "_busy"}, {31'h0, bus.busy}, 32'h1);
    endtask

    initial begin
        bus.data_valid = 1'b0;
        bus.data       = 16'h0000;
        #12;
        check_eq("rst_valid", {31'h0, bus.fir_valid}, 32'h0);
        check_eq("rst_d",     {16'h0, bus.fir_d},     32'h0);
        check_eq("rst_last",  {31'h0, bus.fir_last},  32'h0);
        check_eq("rst_busy",  {31'h0, bus.busy},      32'h0);

        // 1: impulse response
        do_reset();
        run_impulse("imp");

        // 2: DC input 1.0 settles at round(70272/256) = 275
        do_reset();
        for (int i = 0; i < 64; i++) drive_cycle(1'b1, 16'h0100);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'h0000);
        check_eq("dc_count", 32'(out_q.size()), 32'd64);
        if (out_q.size() == 64) begin
            for (int i = 0; i < 64; i++)
                check_eq("dc_model", {16'h0, out_q[i]}, {16'h0, ref_out(i)});
            for (int i = 31; i < 64; i++)
                check_eq("dc_steady", {16'h0, out_q[i]}, 32'h0113);
        end

        // 3: valid on alternate cycles, junk data on the idle ones
        do_reset();
        for (int k = 0; k < 80; k++) drive_cycle((k % 2) == 0, 16'($urandom));
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 16'($urandom));
        check_eq("gap_count", 32'(out_q.size()), 32'd40);
        if (out_q.size() == 40) begin
            for (int i = 0; i < 40; i++) begin
                check_eq("gap_cycle", 32'(ocyc_q[i]), 32'(acc_q[i] + 3));
                check_eq("gap_model", {16'h0, out_q[i]}, {16'h0, ref_out(i)});
            end
        end

        // 4: full-scale input, steady value 35135 clamps or wraps to 0x893F
        do_reset();
        for (int i = 0; i < 40; i++) drive_cycle(1'b1, 16'h7FFF);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'h0000);
        check_eq("ovf_count", 32'(out_q.size()), 32'd40);
        if (out_q.size() == 40) begin
            for (int i = 0; i < 40; i++)
                check_eq("ovf_model", {16'h0, out_q[i]}, {16'h0, ref_out(i)});
`ifdef FIR_SAT_EN
            check_eq("ovf_final", {16'h0, out_q[39]}, 32'h7FFF);
`else
            check_eq("ovf_final", {16'h0, out_q[39]}, 32'h893F);
`endif
        end

        // 5: frame end after 1024 outputs
        do_reset();
        for (int i = 0; i < 1100; i++) drive_cycle(1'b1, 16'($urandom));
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 16'h0000);
        check_eq("frm_count", 32'(out_q.size()), 32'd1024);
        if (out_q.size() == 1024) begin
            int n_last = 0;
            for (int i = 0; i < 1024; i++) begin
                if (last_q[i]) n_last++;
                check_eq("frm_model", {16'h0, out_q[i]}, {16'h0, ref_out(i)});
            end
            check_eq("frm_nlast",   32'(n_last), 32'd1);
            check_eq("frm_last",    {31'h0, last_q[1023]}, 32'h1);
            check_eq("frm_busy_hi", {31'h0, busy_q[1022]}, 32'h1);
            check_eq("frm_busy_lo", {31'h0, busy_q[1023]}, 32'h0);
            check_eq("frm_hold",    {16'h0, bus.fir_d}, {16'h0, ref_out(1023)});
        end
        check_eq("frm_busy_end", {31'h0, bus.busy}, 32'h0);

        // 6: asynchronous reset in the middle of a frame
        do_reset();
        for (int i = 0; i < 500; i++) drive_cycle(1'b1, 16'($urandom_range(16'h7FFF, 16'h0100)));
        check_eq("mid_pre_valid", {31'h0, bus.fir_valid}, 32'h1);
        check_eq("mid_pre_busy",  {31'h0, bus.busy},      32'h1);
        #2;
        rst = 1'b0;
        bus.data_valid = 1'b0;
        #1;
        check_eq("mid_valid", {31'h0, bus.fir_valid}, 32'h0);
        check_eq("mid_d",     {16'h0, bus.fir_d},     32'h0);
        check_eq("mid_last",  {31'h0, bus.fir_last},  32'h0);
        check_eq("mid_busy",  {31'h0, bus.busy},      32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_log();
        run_impulse("rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "watchdog expired");
    end

endmodule
